// File: rtl/pixel_sink_pkg.sv
// Shared constants and payload type for the pixel write sink.
package pixel_sink_pkg;
  localparam int unsigned SCREEN_X  = 160;
  localparam int unsigned SCREEN_Y  = 120;
  localparam int unsigned DEPTH_DEF = 16;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color;
  } pix_t;

  localparam int unsigned PIX_W = $bits(pix_t);
endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with a registered head word, so the output never
// depends combinationally on push/pop inputs.
module pixel_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 18
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    i_clear,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [WIDTH-1:0]        i_data,
  output logic [WIDTH-1:0]        o_data,
  output logic                    o_valid,
  output logic                    o_full,
  output logic [$clog2(DEPTH):0]  o_count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr, r_rd, w_rd_nxt;
  logic [CNT_W-1:0] r_count, w_cnt_nxt;
  logic [WIDTH-1:0] r_data, w_head_nxt;
  logic             r_valid, r_full;
  logic             w_push, w_pop;

  assign w_pop  = i_pop & (r_count != '0);
  assign w_push = i_push & ((r_count != CNT_W'(DEPTH)) | w_pop);

  // Next head: the incoming word when it lands in an otherwise empty FIFO.
  always_comb begin
    w_rd_nxt   = r_rd + PTR_W'(w_pop);
    w_cnt_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    w_head_nxt = r_mem[w_rd_nxt];
    if (w_cnt_nxt == '0) begin
      w_head_nxt = '0;
    end else if (w_push && (r_count == CNT_W'(w_pop))) begin
      w_head_nxt = i_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_full  <= 1'b0;
    end else if (i_clear) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      r_wr    <= r_wr + PTR_W'(w_push);
      r_rd    <= w_rd_nxt;
      r_count <= w_cnt_nxt;
      r_data  <= w_head_nxt;
      r_valid <= (w_cnt_nxt != '0);
      r_full  <= (w_cnt_nxt == CNT_W'(DEPTH));
    end
  end

  // Storage carries no reset; contents are qualified by the count.
  always_ff @(posedge clk) begin
    if (w_push && !i_clear) begin
      r_mem[r_wr] <= i_data;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_full  = r_full;
  assign o_count = r_count;
endmodule

// File: rtl/pixel_sink.sv
// Buffers drawer pixel writes, drops off-screen pixels and hands the rest
// downstream through a valid/ready handshake.
module pixel_sink
  import pixel_sink_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned XMAX  = SCREEN_X,
  parameter int unsigned YMAX  = SCREEN_Y
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       writeEn,
  input  logic [9:0] x_in,
  input  logic [9:0] y_in,
  input  logic [2:0] color_in,
  input  logic       clear,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_x,
  output logic [6:0] out_y,
  output logic [2:0] out_color,
  output logic       full,
  output logic       overflow,
  output logic [7:0] clip_count
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             w_in_range, w_legal, w_clip, w_pop, w_push;
  logic [CNT_W-1:0] w_count;
  pix_t             w_pix_in, w_head;
  logic             r_overflow;
  logic [7:0]       r_clip;

  // Range check uses the full 10-bit coordinates before truncation.
  assign w_in_range = (x_in < 10'(XMAX)) && (y_in < 10'(YMAX));
  assign w_legal    = writeEn & ~clear & w_in_range;
  assign w_clip     = writeEn & ~clear & ~w_in_range;
  assign w_pop      = out_valid & out_ready;
  assign w_push     = w_legal & ((w_count != CNT_W'(DEPTH)) | w_pop);

  assign w_pix_in = '{x: x_in[7:0], y: y_in[6:0], color: color_in};

  pixel_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_clear (clear),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pix_in),
    .o_data  (w_head),
    .o_valid (out_valid),
    .o_full  (full),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overflow <= 1'b0;
      r_clip     <= '0;
    end else if (clear) begin
      r_overflow <= 1'b0;
      r_clip     <= '0;
    end else begin
      if (w_legal && !w_push) begin
        r_overflow <= 1'b1;
      end
      if (w_clip && (r_clip != 8'hFF)) begin
        r_clip <= r_clip + 8'd1;
      end
    end
  end

  assign out_x      = w_head.x;
  assign out_y      = w_head.y;
  assign out_color  = w_head.color;
  assign overflow   = r_overflow;
  assign clip_count = r_clip;
endmodule
